// File: rtl/systolic_feed_ctrl.sv
// Operand sequencer for a 4x4 output-stationary systolic array.
// Latches A/B, clears the array, feeds skewed wavefronts, waits for done.
module systolic_feed_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DRAIN_MAX  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     ready_o,
  input  logic [16*DATA_WIDTH-1:0] mat_a_i,
  input  logic [16*DATA_WIDTH-1:0] mat_b_i,
  output logic [4*DATA_WIDTH-1:0]  left_o,
  output logic [4*DATA_WIDTH-1:0]  up_o,
  output logic                     arr_rst_no,
  input  logic                     arr_done_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         t_q, t_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [16*DW-1:0]   a_q, a_d;
  logic [16*DW-1:0]   b_q, b_d;
  logic [4*DW-1:0]    left_q, left_d;
  logic [4*DW-1:0]    up_q, up_d;
  logic               ready_q, ready_d;
  logic               arr_rst_n_q, arr_rst_n_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Element entering lane `lane` at wavefront step t; zero outside the skew window.
  function automatic logic [DW-1:0] sel(
    input logic [16*DW-1:0] m,
    input logic [2:0]       t,
    input int               lane,
    input logic             row
  );
    int k;
    int idx;
    k   = int'(t) - lane;
    idx = row ? (4 * lane + k) : (4 * k + lane);
    sel = '0;
    if (k >= 0 && k <= 3) sel = m[idx*DW +: DW];
  endfunction

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLEAR;
          a_d     = mat_a_i;
          b_d     = mat_b_i;
          err_d   = 1'b0;
        end
      end
      CLEAR: begin
        state_d = FEED;
        t_d     = 3'd0;
      end
      FEED: begin
        if (t_q == 3'd6) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          t_d = t_q + 3'd1;
        end
      end
      DRAIN: begin
        if (arr_done_i) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers.
  always_comb begin
    left_d      = '0;
    up_d        = '0;
    ready_d     = (state_d == IDLE);
    arr_rst_n_d = (state_d != CLEAR);
    done_d      = (state_d == DONE);
    if (state_d == FEED) begin
      for (int i = 0; i < 4; i++) begin
        left_d[i*DW +: DW] = sel(a_q, t_d, i, 1'b1);
        up_d[i*DW +: DW]   = sel(b_q, t_d, i, 1'b0);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      t_q         <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      left_q      <= '0;
      up_q        <= '0;
      ready_q     <= 1'b1;
      arr_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      left_q      <= left_d;
      up_q        <= up_d;
      ready_q     <= ready_d;
      arr_rst_n_q <= arr_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ready_o    = ready_q;
  assign busy_o     = ~ready_q;
  assign left_o     = left_q;
  assign up_o       = up_q;
  assign arr_rst_no = arr_rst_n_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl with a behavioural 4x4 array.
// Checks feed wavefronts, results, timeout, reset and back-to-back starts.
module tb_systolic_feed_ctrl;

  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic            arr_done;
  logic [16*DW-1:0] ma, mb;
  logic            ready, busy, done, err, arr_rst_n;
  logic [4*DW-1:0] left, up;

  int n_cmp = 0;
  int n_bad = 0;
  int donecnt = 0;
  int lowcnt = 0;
  int d0, l0;

  systolic_feed_ctrl #(.DATA_WIDTH(DW), .DRAIN_MAX(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .ready_o    (ready),
    .mat_a_i    (ma),
    .mat_b_i    (mb),
    .left_o     (left),
    .up_o       (up),
    .arr_rst_no (arr_rst_n),
    .arr_done_i (arr_done),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural output-stationary array: a flows right, b flows down.
  logic [DW-1:0] ah [4][4];
  logic [DW-1:0] bv [4][4];
  logic [DW-1:0] acc[4][4];
  logic [DW-1:0] ain[4][4];
  logic [DW-1:0] bin[4][4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ain[r][c] = (c == 0) ? left[r*DW +: DW] : ah[r][(c+3)%4];
        bin[r][c] = (r == 0) ? up[c*DW +: DW] : bv[(r+3)%4][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!arr_rst_n) begin
          ah[r][c]  <= '0;
          bv[r][c]  <= '0;
          acc[r][c] <= '0;
        end else begin
          ah[r][c]  <= ain[r][c];
          bv[r][c]  <= bin[r][c];
          acc[r][c] <= acc[r][c] + ain[r][c] * bin[r][c];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done) donecnt++;
    if (!rst && !arr_rst_n) lowcnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [4*DW-1:0] p4(input int x0, input int x1,
                                         input int x2, input int x3);
    p4 = {DW'(x3), DW'(x2), DW'(x1), DW'(x0)};
  endfunction

  task automatic load_a();
    for (int i = 0; i < 16; i++) ma[i*DW +: DW] = DW'(i + 1);
  endtask

  task automatic load_b1();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) mb[(4*k+c)*DW +: DW] = DW'(c + 1);
  endtask

  task automatic load_b2();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++)
        mb[(4*k+c)*DW +: DW] = (k == c) ? DW'(2) : DW'(0);
  endtask

  task automatic accept();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    arr_done = 1'b0;
    ma = '0;
    mb = '0;
    tick(2);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_left", left, 0);
    chk("rst_up", up, 0);
    chk("rst_arrn", arr_rst_n, 0);
    rst = 1'b0;
    tick(1);
    chk("idle_arrn", arr_rst_n, 1);

    // reset during FEED
    load_a();
    load_b1();
    accept();
    tick(3);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_ready", ready, 1);
    chk("mid_busy0", busy, 0);
    chk("mid_left", left, 0);
    chk("mid_up", up, 0);
    chk("mid_arrn", arr_rst_n, 0);
    d0 = donecnt;
    tick(2);
    chk("mid_done", done, 0);
    chk("mid_arrn2", arr_rst_n, 0);
    rst = 1'b0;
    tick(1);
    chk("mid_arrn_rel", arr_rst_n, 1);
    chk("mid_nodone", donecnt - d0, 0);

    // full run with wavefront checks
    d0 = donecnt;
    l0 = lowcnt;
    accept();
    chk("clr_arrn", arr_rst_n, 0);
    chk("clr_busy", busy, 1);
    chk("clr_left", left, 0);
    tick(1);
    chk("t0_left", left, p4(1, 0, 0, 0));
    chk("t0_up", up, p4(1, 0, 0, 0));
    chk("t0_arrn", arr_rst_n, 1);
    tick(1);
    chk("t1_left", left, p4(2, 5, 0, 0));
    chk("t1_up", up, p4(1, 2, 0, 0));
    tick(2);
    chk("t3_left", left, p4(4, 7, 10, 13));
    chk("t3_up", up, p4(1, 2, 3, 4));
    tick(3);
    chk("t6_left", left, p4(0, 0, 0, 16));
    chk("t6_up", up, p4(0, 0, 0, 4));
    tick(1);
    chk("dr_left", left, 0);
    chk("dr_up", up, 0);
    chk("dr_busy", busy, 1);
    tick(6);
    chk("dr_done0", done, 0);
    arr_done = 1'b1;
    tick(1);
    arr_done = 1'b0;
    chk("run_done", done, 1);
    chk("run_err", err, 0);
    tick(1);
    chk("run_done_off", done, 0);
    chk("run_ready", ready, 1);
    chk("C11", acc[0][0], 10);
    chk("C12", acc[0][1], 20);
    chk("C23", acc[1][2], 3 * 26);
    chk("C44", acc[3][3], 232);
    chk("one_pulse", donecnt - d0, 1);
    chk("one_clear", lowcnt - l0, 1);

    // start during FEED with other operands is ignored
    accept();
    tick(2);
    ma = {16{DW'(99)}};
    mb = {16{DW'(77)}};
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("ign_t2_left", left, p4(3, 6, 9, 0));
    tick(1);
    chk("ign_t3_left", left, p4(4, 7, 10, 13));
    chk("ign_t3_up", up, p4(1, 2, 3, 4));
    load_a();
    load_b1();
    tick(4);
    chk("ign_drain", busy, 1);
    tick(5);
    arr_done = 1'b1;
    tick(1);
    arr_done = 1'b0;
    chk("ign_done", done, 1);
    chk("ign_C44", acc[3][3], 232);
    tick(1);

    // drain timeout
    accept();
    tick(8);
    tick(15);
    chk("to_not_yet", done, 0);
    chk("to_busy", busy, 1);
    tick(1);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    tick(1);
    chk("to_err_sticky", err, 1);
    chk("to_ready", ready, 1);

    // err cleared on start; done ignored outside DRAIN; done wins on last cnt
    accept();
    chk("clr_err", err, 0);
    tick(1);
    arr_done = 1'b1;
    tick(1);
    arr_done = 1'b0;
    chk("feed_done_ign", done, 0);
    chk("feed_busy", busy, 1);
    tick(6);
    tick(15);
    chk("last_not_yet", done, 0);
    arr_done = 1'b1;
    tick(1);
    arr_done = 1'b0;
    chk("last_done", done, 1);
    chk("last_err", err, 0);
    tick(1);

    // back-to-back with start held high
    start = 1'b1;
    tick(1);
    chk("b2b_clr", arr_rst_n, 0);
    load_b2();
    tick(8);
    tick(6);
    arr_done = 1'b1;
    tick(1);
    arr_done = 1'b0;
    chk("b2b_done1", done, 1);
    chk("b2b_C44a", acc[3][3], 232);
    tick(1);
    chk("b2b_ready", ready, 1);
    tick(1);
    chk("b2b_reacc", arr_rst_n, 0);
    chk("b2b_busy", busy, 1);
    start = 1'b0;
    tick(8);
    tick(6);
    arr_done = 1'b1;
    tick(1);
    arr_done = 1'b0;
    chk("b2b_done2", done, 1);
    chk("b2b_C11", acc[0][0], 2);
    chk("b2b_C23", acc[1][2], 14);
    chk("b2b_C12", acc[0][1], 4);
    chk("b2b_C44", acc[3][3], 32);
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
